// File: rtl/pcount_pkg.sv
// Shared types and constants for the pulse-count window controller.
package pcount_pkg;

  typedef enum logic [1:0] {
    StCount  = 2'd0,
    StShiftH = 2'd1,
    StShiftT = 2'd2,
    StShiftO = 2'd3
  } state_e;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t h;
    bcd_digit_t t;
    bcd_digit_t o;
  } bcd3_t;

  localparam bcd_digit_t BLANK_DIGIT = 4'hF;
  localparam bcd_digit_t BCD_MAX_H   = 4'd9;
  localparam bcd_digit_t BCD_MAX_T   = 4'd9;
  localparam bcd_digit_t BCD_MAX_O   = 4'd9;

  function automatic logic bcd3_is_max(input bcd3_t v);
    return (v.h == BCD_MAX_H) && (v.t == BCD_MAX_T) && (v.o == BCD_MAX_O);
  endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit saturating BCD counter with synchronous clear. Outputs show the value and
// saturate flag as they stand after this cycle's increment, before any clear.
module bcd_counter3
  import pcount_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  inc,
  output bcd3_t count,
  output logic  sat
);

  bcd3_t count_q, count_d;
  logic  sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    sat_d   = sat_q;
    if (inc) begin
      if (bcd3_is_max(count_q)) begin
        sat_d = 1'b1;
      end else if (count_q.o != 4'd9) begin
        count_d.o = count_q.o + 4'd1;
      end else begin
        count_d.o = 4'd0;
        if (count_q.t != 4'd9) begin
          count_d.t = count_q.t + 4'd1;
        end else begin
          count_d.t = 4'd0;
          count_d.h = count_q.h + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_d;
  assign sat   = sat_d;

endmodule

// File: rtl/pcount_ctrl.sv
// Windowed pulse counter: counts pulses per WINDOW_TICKS ticks and shifts the BCD result
// out as three digits. Define PCOUNT_CTRL_LEADZ_EN for leading-zero blanking.
module pcount_ctrl
  import pcount_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       pulse,
  output logic [3:0] q_out,
  output logic       iden,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  localparam logic [7:0] LAST_TICK = 8'(WINDOW_TICKS - 1);

  state_e     state_q, state_d;
  logic [7:0] tcnt_q, tcnt_d;
  bcd3_t      snap_q, snap_d;
  bcd3_t      pend_snap_q, pend_snap_d;
  logic       pend_q, pend_d;
  logic       done_q;
  logic       ovf_q;
  logic       close;
  bcd3_t      cnt_nxt;
  logic       sat_nxt;

  // The closing-cycle pulse is included in cnt_nxt, then the clear wins in the counter.
  bcd_counter3 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .clr   (close),
    .inc   (pulse),
    .count (cnt_nxt),
    .sat   (sat_nxt)
  );

  always_comb begin
    close  = tick && (tcnt_q == LAST_TICK);
    tcnt_d = tcnt_q;
    if (tick) begin
      tcnt_d = close ? 8'd0 : tcnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    pend_snap_d = pend_snap_q;
    pend_d      = pend_q;
    unique case (state_q)
      StCount: begin
        // A held-over window goes first; a close in this same cycle is dropped.
        if (pend_q) begin
          snap_d  = pend_snap_q;
          pend_d  = 1'b0;
          state_d = StShiftH;
        end else if (close) begin
          snap_d  = cnt_nxt;
          state_d = StShiftH;
        end
      end
      StShiftH: state_d = StShiftT;
      StShiftT: state_d = StShiftO;
      StShiftO: state_d = StCount;
      default:  state_d = StCount;
    endcase
    if ((state_q != StCount) && close && !pend_q) begin
      pend_d      = 1'b1;
      pend_snap_d = cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StCount;
      tcnt_q      <= 8'd0;
      snap_q      <= '0;
      pend_snap_q <= '0;
      pend_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      snap_q      <= snap_d;
      pend_snap_q <= pend_snap_d;
      pend_q      <= pend_d;
      done_q      <= (state_q == StShiftO);
      if (close) begin
        ovf_q <= sat_nxt;
      end
    end
  end

  always_comb begin
    q_out = 4'h0;
    unique case (state_q)
      StCount: q_out = 4'h0;
`ifdef PCOUNT_CTRL_LEADZ_EN
      StShiftH: q_out = (snap_q.h == 4'd0) ? BLANK_DIGIT : snap_q.h;
      StShiftT: q_out = ((snap_q.h == 4'd0) && (snap_q.t == 4'd0)) ? BLANK_DIGIT : snap_q.t;
`else
      StShiftH: q_out = snap_q.h;
      StShiftT: q_out = snap_q.t;
`endif
      StShiftO: q_out = snap_q.o;
      default:  q_out = 4'h0;
    endcase
  end

  assign iden = (state_q != StCount);
  assign busy = (state_q != StCount);
  assign done = done_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pcount_ctrl.sv
// Directed bench for pcount_ctrl: a WINDOW_TICKS=4 instance and a WINDOW_TICKS=1 instance.
module tb_pcount_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_a = 1'b0, pulse_a = 1'b0, tick_b = 1'b0, pulse_b = 1'b0;
  logic [3:0] q_a, q_b;
  logic       iden_a, busy_a, done_a, ovf_a;
  logic       iden_b, busy_b, done_b, ovf_b;
  logic       sel_b = 1'b0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  pcount_ctrl #(.WINDOW_TICKS(4)) u_dut_a (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick_a),
    .pulse (pulse_a),
    .q_out (q_a),
    .iden  (iden_a),
    .busy  (busy_a),
    .done  (done_a),
    .ovf   (ovf_a)
  );

  pcount_ctrl #(.WINDOW_TICKS(1)) u_dut_b (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick_b),
    .pulse (pulse_b),
    .q_out (q_b),
    .iden  (iden_b),
    .busy  (busy_b),
    .done  (done_b),
    .ovf   (ovf_b)
  );

  logic [3:0] q_m;
  logic       iden_m, busy_m, done_m, ovf_m;
  assign q_m    = sel_b ? q_b : q_a;
  assign iden_m = sel_b ? iden_b : iden_a;
  assign busy_m = sel_b ? busy_b : busy_a;
  assign done_m = sel_b ? done_b : done_a;
  assign ovf_m  = sel_b ? ovf_b : ovf_a;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one clock cycle into the selected instance, then settle past the edge.
  task automatic cycle(input logic p, input logic t);
    pulse_a = sel_b ? 1'b0 : p;
    tick_a  = sel_b ? 1'b0 : t;
    pulse_b = sel_b ? p : 1'b0;
    tick_b  = sel_b ? t : 1'b0;
    @(posedge clk);
    #1;
    pulse_a = 1'b0;
    tick_a  = 1'b0;
    pulse_b = 1'b0;
    tick_b  = 1'b0;
  endtask

  // Digit expected on q_out for position 2=hundreds, 1=tens, 0=ones.
  function automatic logic [3:0] shown(input int pos, input logic [3:0] h, t, o);
`ifdef PCOUNT_CTRL_LEADZ_EN
    if (pos == 2 && h == 4'd0) return 4'hF;
    if (pos == 1 && h == 4'd0 && t == 4'd0) return 4'hF;
`endif
    if (pos == 2) return h;
    if (pos == 1) return t;
    return o;
  endfunction

  // Called right after the closing edge: checks the full shift sequence and done strobe.
  task automatic expect_window(input string tag, input logic [3:0] h, t, o, input logic v);
    check({tag, "_iden_h"}, 32'(iden_m), 1);
    check({tag, "_busy_h"}, 32'(busy_m), 1);
    check({tag, "_q_h"}, 32'(q_m), 32'(shown(2, h, t, o)));
    cycle(1'b0, 1'b0);
    check({tag, "_q_t"}, 32'(q_m), 32'(shown(1, h, t, o)));
    cycle(1'b0, 1'b0);
    check({tag, "_q_o"}, 32'(q_m), 32'(shown(0, h, t, o)));
    cycle(1'b0, 1'b0);
    check({tag, "_iden_end"}, 32'(iden_m), 0);
    check({tag, "_done"}, 32'(done_m), 1);
    check({tag, "_ovf"}, 32'(ovf_m), 32'(v));
    cycle(1'b0, 1'b0);
    check({tag, "_done_off"}, 32'(done_m), 0);
    check({tag, "_busy_off"}, 32'(busy_m), 0);
  endtask

  // Three plain ticks then the closing tick on the WINDOW_TICKS=4 instance.
  task automatic close_a(input logic p);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    cycle(p, 1'b1);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    check("rst_q_a", 32'(q_a), 0);
    check("rst_iden_a", 32'(iden_a), 0);
    check("rst_busy_a", 32'(busy_a), 0);
    check("rst_done_a", 32'(done_a), 0);
    check("rst_ovf_a", 32'(ovf_a), 0);
    check("rst_iden_b", 32'(iden_b), 0);
    rst = 1'b1;
    cycle(1'b0, 1'b0);

    // Back-to-back closes on the single-tick instance exercise the pending path.
    sel_b = 1'b1;
    pulses(5);
    cycle(1'b0, 1'b1);
    check("pend_h1", 32'(q_m), 32'(shown(2, 4'd0, 4'd0, 4'd5)));
    cycle(1'b1, 1'b1);
    check("pend_t1", 32'(q_m), 32'(shown(1, 4'd0, 4'd0, 4'd5)));
    cycle(1'b1, 1'b0);
    check("pend_o1", 32'(q_m), 32'(shown(0, 4'd0, 4'd0, 4'd5)));
    cycle(1'b1, 1'b1);
    check("pend_done1", 32'(done_m), 1);
    check("pend_iden_gap", 32'(iden_m), 0);
    cycle(1'b0, 1'b0);
    check("pend_iden2", 32'(iden_m), 1);
    check("pend_h2", 32'(q_m), 32'(shown(2, 4'd0, 4'd0, 4'd1)));
    cycle(1'b0, 1'b0);
    check("pend_t2", 32'(q_m), 32'(shown(1, 4'd0, 4'd0, 4'd1)));
    cycle(1'b0, 1'b0);
    check("pend_o2", 32'(q_m), 32'(shown(0, 4'd0, 4'd0, 4'd1)));
    cycle(1'b0, 1'b0);
    check("pend_done2", 32'(done_m), 1);
    cycle(1'b0, 1'b0);
    check("pend_no_third", 32'(busy_m), 0);
    check("pend_done_off", 32'(done_m), 0);
    cycle(1'b0, 1'b1);
    expect_window("pend_after", 4'd0, 4'd0, 4'd0, 1'b0);
    sel_b = 1'b0;

    pulses(123);
    close_a(1'b0);
    expect_window("w123", 4'd1, 4'd2, 4'd3, 1'b0);

    pulses(1005);
    close_a(1'b0);
    expect_window("sat", 4'd9, 4'd9, 4'd9, 1'b1);
    pulses(5);
    close_a(1'b0);
    expect_window("after_sat", 4'd0, 4'd0, 4'd5, 1'b0);

    pulses(41);
    close_a(1'b1);
    expect_window("coinc", 4'd0, 4'd4, 4'd2, 1'b0);
    close_a(1'b0);
    expect_window("empty", 4'd0, 4'd0, 4'd0, 1'b0);

    // Reset asserted while the tens digit is on the chain.
    pulses(12);
    close_a(1'b0);
    check("mid_h", 32'(q_m), 32'(shown(2, 4'd0, 4'd1, 4'd2)));
    cycle(1'b0, 1'b0);
    check("mid_t", 32'(q_m), 32'(shown(1, 4'd0, 4'd1, 4'd2)));
    rst = 1'b0;
    cycle(1'b0, 1'b0);
    check("mid_rst_iden", 32'(iden_m), 0);
    check("mid_rst_busy", 32'(busy_m), 0);
    check("mid_rst_q", 32'(q_m), 0);
    rst = 1'b1;
    cycle(1'b0, 1'b0);
    check("mid_rst_done", 32'(done_m), 0);
    check("mid_rst_busy2", 32'(busy_m), 0);
    pulses(7);
    close_a(1'b0);
    expect_window("post_rst", 4'd0, 4'd0, 4'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcount_ctrl.md
PCOUNT_CTRL -- requirements
Module: pcount_ctrl

Interface
REQ-001 Parameter WINDOW_TICKS, default 15, number of tick strobes per measurement window; legal range 1..255.
REQ-002 clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 tick  input  1  one-cycle timebase strobe, already synchronous to clk.
REQ-005 pulse  input  1  one-cycle pulse-detected strobe, already synchronous to clk.
REQ-006 q_out  output  4  digit presented to the 3-stage digit shift chain.
REQ-007 iden  output  1  shift enable for the digit chain; q_out valid whenever iden=1.
REQ-008 busy  output  1  high in any SHIFT state.
REQ-009 done  output  1  one-cycle strobe after the third digit is shifted.
REQ-010 ovf  output  1  count saturated in the last reported window.

Function
REQ-011 Window: tick counter counts tick strobes 0..WINDOW_TICKS-1 continuously in every state; a tick at count WINDOW_TICKS-1 closes the window and returns the counter to 0.
REQ-012 Pulse count: 3-digit BCD counter (000..999) increments by 1 per pulse; at 999 it holds (saturates) and sets an internal ovf flag.
REQ-013 On window close: snapshot = BCD count including any pulse in the same cycle; BCD counter clears to 000, or to 001 if pulse is also high that cycle is not allowed: the closing-cycle pulse belongs to the closing window only.
REQ-014 On window close: ovf output loads the internal ovf flag; internal flag clears.
REQ-015 FSM states: COUNT, SHIFT_H, SHIFT_T, SHIFT_O; COUNT -> SHIFT_H on window close or pending flag; SHIFT_H -> SHIFT_T -> SHIFT_O -> COUNT unconditionally, one cycle each.
REQ-016 SHIFT_H, SHIFT_T, SHIFT_O drive iden=1 with q_out = snapshot hundreds, tens, ones respectively (hundreds ends in the first chain stage's far end, ones in the entry stage).
REQ-017 In COUNT, iden=0 and q_out=4'h0.
REQ-018 done=1 exactly in the cycle after SHIFT_O (first COUNT cycle), registered.
REQ-019 Window close during a SHIFT state sets a pending flag and takes a new snapshot only after SHIFT_O completes; snapshot in use is not overwritten mid-shift.
REQ-020 Pending flag: COUNT with pending set goes to SHIFT_H the next cycle; pending clears on entry to SHIFT_H; a second close while pending is set is dropped (count still clears).
REQ-021 Pulses and ticks during SHIFT states are counted into the current (new) window; none lost.

Reset
REQ-022 rst=0 at a clock edge forces state COUNT, tick counter 0, BCD count 000, snapshot 000, pending 0, internal ovf 0.
REQ-023 During and after reset: q_out=0, iden=0, busy=0, done=0, ovf=0; reset mid-shift abandons the remaining digits.

Configuration
REQ-024 Macro PCOUNT_CTRL_LEADZ_EN defined: leading-zero blanking; hundreds digit 0 is shifted as 4'hF; tens digit 0 shifted as 4'hF when hundreds also 0; ones never blanked.
REQ-025 Macro undefined: all three digits shifted raw, no blanking logic present.

Structure
REQ-026 Shared package pcount_pkg holds: state enum typedef, bcd_digit_t (4-bit), BLANK_DIGIT = 4'hF, BCD_MAX = 999 as three digit constants.
REQ-027 One sub-module bcd_counter3: 3-digit saturating BCD counter with synchronous clear, increment and saturate flag; FSM, tick counter and snapshot remain in pcount_ctrl.

Verification
REQ-028 WINDOW_TICKS=4, 123 pulses then 4 ticks -> iden high 3 cycles with q_out 1,2,3; done 1 cycle later; ovf=0.
REQ-029 1005 pulses then window close -> digits 9,9,9, ovf=1; next window with 5 pulses -> 0,0,5 (or F,F,5 with PCOUNT_CTRL_LEADZ_EN), ovf=0.
REQ-030 Pulse coincident with closing tick after 41 pulses -> reported 042; following window with 0 pulses reports 000.
REQ-031 WINDOW_TICKS=1, ticks on consecutive cycles -> pending path: second snapshot shifted immediately after first done, third close while pending dropped, no digit corrupted.
REQ-032 rst=0 asserted in SHIFT_T -> next cycle iden=0, busy=0, no done; later window with 7 pulses reports 007.
